clock_set_controller: RTL and testbench

- Mode and sequencing controller for the digital clock.
- Debounces the three user buttons and generates the 1 Hz run tick.
- Steps a RUN/SET_HOUR/SET_MIN/SET_SEC state machine.
- Drives the hour/minute/second counters with select, increment/decrement pulses and a run enable; the counters' own carry chain stays outside this block.

---
 rtl/clock_pkg.sv | 13 +
 rtl/btn_debounce.sv | 34 +++
 rtl/clock_set_controller.sv | 70 +++++++
 tb/tb_clock_set_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: state encoding, default clock rate and mode sequencing for the digital clock controller
package clock_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;
  localparam int CLK_HZ = 50000000;
  function automatic state_t next_state(input state_t s);
    return s == ST_RUN ? ST_SET_HOUR : s == ST_SET_HOUR ? ST_SET_MIN : s == ST_SET_MIN ? ST_SET_SEC : ST_RUN;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises, debounces and edge-detects one active-low push button
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk50,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  logic differ;
  assign differ = sync[1] != level;
  // two-flop synchroniser, stability counter, and a press pulse on the debounced falling edge only
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw_n};
      cnt     <= (!differ || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      level   <= (differ && cnt == CNT_MAX) ? sync[1] : level;
      level_d <= level;
      press   <= level_d & ~level;
    end
  end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: button handling, RUN/SET mode FSM, 1 Hz tick and set-mode blink for the digital clock
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = CLK_HZ,
  parameter int DEB_CYCLES = 1000000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       btn_mode_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic       tick_1hz,
  output logic       run_en,
  output logic       sel_hour,
  output logic       sel_min,
  output logic       sel_sec,
  output logic       inc,
  output logic       dec,
  output logic       blink,
  output logic [1:0] mode
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);
  logic mode_ev, up_ev, dn_ev;
  logic [2:0] unused_lvl;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic stay_run, set_edit;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk50(clk50), .reset(reset), .raw_n(btn_mode_n), .level(unused_lvl[0]), .press(mode_ev)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk50(clk50), .reset(reset), .raw_n(btn_up_n), .level(unused_lvl[1]), .press(up_ev)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
    .clk50(clk50), .reset(reset), .raw_n(btn_down_n), .level(unused_lvl[2]), .press(dn_ev)
  );
  assign stay_run = state == ST_RUN && !mode_ev;
  assign set_edit = state != ST_RUN && !mode_ev;
  assign run_en   = state == ST_RUN;
  assign sel_hour = state == ST_SET_HOUR;
  assign sel_min  = state == ST_SET_MIN;
  assign sel_sec  = state == ST_SET_SEC;
  assign mode     = state;
  // mode stepping, edit pulses, tick prescaler and blink divider; any state change restarts both dividers
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      tcnt     <= '0;
      bcnt     <= '0;
      tick_1hz <= 1'b0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state    <= mode_ev ? next_state(state) : state;
      inc      <= set_edit & up_ev & ~dn_ev;
      dec      <= set_edit & dn_ev & ~up_ev;
      tcnt     <= (!stay_run || tcnt == T_MAX) ? '0 : tcnt + 1'b1;
      tick_1hz <= stay_run && tcnt == T_MAX;
      bcnt     <= (!set_edit || bcnt == B_MAX) ? '0 : bcnt + 1'b1;
      blink    <= !set_edit ? 1'b0 : (bcnt == B_MAX ? ~blink : blink);
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: scoreboard bench for the clock mode/sequencing controller
module tb_clock_set_controller;
  logic clk50 = 1'b0;
  logic reset = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic tick_1hz, run_en, sel_hour, sel_min, sel_sec, inc, dec, blink;
  logic [1:0] mode;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int exp_mode = 0, prev_mode = 0, idx = 0, cyc = 0, enter = 0, last_tick = 0, tick_cnt = 0;
  int ev, want_ev;
  bit first_pending = 1'b1;

  always #5 clk50 = ~clk50;

  clock_set_controller #(.TICK_DIV(10), .DEB_CYCLES(4), .BLINK_DIV(5)) dut (
    .clk50(clk50), .reset(reset),
    .btn_mode_n(btn_n[0]), .btn_up_n(btn_n[1]), .btn_down_n(btn_n[2]),
    .tick_1hz(tick_1hz), .run_en(run_en), .sel_hour(sel_hour), .sel_min(sel_min), .sel_sec(sel_sec),
    .inc(inc), .dec(dec), .blink(blink), .mode(mode)
  );

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk50);
  endtask

  // b: {down, up, mode} pressed bits, held low across `hold` clock edges
  task automatic press(input logic [2:0] b, input int hold);
    @(negedge clk50);
    btn_n = ~b;
    idle(hold);
    btn_n = 3'b111;
    idle(14);
  endtask

  // event codes: 0 inc, 1 dec, 2+m mode became m
  always @(posedge clk50) begin
    #1;
    cyc++;
    if (!reset) begin
      prev_mode = int'(mode);
      exp_mode = 0;
      enter = cyc;
      first_pending = 1'b1;
      idx = 0;
    end else begin
      ev = inc ? 0 : dec ? 1 : (int'(mode) != prev_mode) ? 2 + int'(mode) : -1;
      if (ev >= 0) begin
        if (exp_q.size() == 0) check("unexpected_event", ev, -1);
        else begin
          want_ev = exp_q.pop_front();
          check("event", ev, want_ev);
          if (want_ev >= 2) exp_mode = want_ev - 2;
        end
      end
      if (int'(mode) != prev_mode) begin
        idx = 0;
        if (mode == 2'd0) begin
          enter = cyc;
          first_pending = 1'b1;
        end
      end else idx++;
      prev_mode = int'(mode);
      check("decode", {mode, run_en, sel_hour, sel_min, sel_sec},
            {exp_mode[1:0], exp_mode == 0, exp_mode == 1, exp_mode == 2, exp_mode == 3});
      check("blink", blink, exp_mode == 0 ? 0 : (idx / 5) % 2);
      if (inc || dec) check("incdec_legal", {inc & dec, exp_mode == 0}, 0);
      if (tick_1hz) begin
        tick_cnt++;
        check("tick_in_run", exp_mode, 0);
        if (first_pending) check("first_tick", cyc - enter, 10);
        else check("tick_period", cyc - last_tick, 10);
        first_pending = 1'b0;
        last_tick = cyc;
      end
    end
  end

  initial begin
    int t0;
    idle(3);
    check("rst_out", {tick_1hz, inc, dec, blink, sel_hour, sel_min, sel_sec, run_en, mode}, 10'b0000000100);
    reset = 1'b1;
    t0 = tick_cnt;
    idle(35);
    check("tick_count", tick_cnt - t0, 3);
    press(3'b010, 8);
    press(3'b001, 2);
    exp_q.push_back(3);
    press(3'b001, 8);
    check("set_hour", {mode, sel_hour, run_en, tick_1hz}, 5'b01100);
    exp_q.push_back(4);
    press(3'b011, 8);
    exp_q.push_back(0);
    press(3'b010, 8);
    exp_q.push_back(1);
    press(3'b100, 8);
    press(3'b110, 8);
    exp_q.push_back(5);
    press(3'b001, 8);
    exp_q.push_back(2);
    press(3'b001, 8);
    idle(20);
    exp_q.push_back(3);
    press(3'b001, 8);
    exp_q.push_back(4);
    press(3'b001, 8);
    exp_q.push_back(5);
    press(3'b001, 8);
    check("set_sec", mode, 3);
    @(negedge clk50);
    btn_n = 3'b101;
    idle(4);
    reset = 1'b0;
    #1;
    check("async_rst", {tick_1hz, inc, dec, blink, sel_hour, sel_min, sel_sec, run_en, mode}, 10'b0000000100);
    idle(2);
    btn_n = 3'b111;
    idle(3);
    reset = 1'b1;
    idle(25);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
